// File: rtl/collision_pkg.sv
// collision_pkg: collision box type and the pairwise overlap test.
package collision_pkg;
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [9:0] w;
      logic [9:0] h;
   } collision_box_t;
   // Sums are one bit wider so a box touching the far edge of the screen cannot wrap.
   function automatic logic box_compare(input collision_box_t a, input collision_box_t b);
      return ({1'b0, a.x} < {1'b0, b.x} + {1'b0, b.w}) && ({1'b0, b.x} < {1'b0, a.x} + {1'b0, a.w}) &&
             ({1'b0, a.y} < {1'b0, b.y} + {1'b0, b.h}) && ({1'b0, b.y} < {1'b0, a.y} + {1'b0, a.h});
   endfunction
endpackage

// File: rtl/game_loop_pkg.sv
// game_loop_pkg: game state type and default loop constants.
package game_loop_pkg;
   typedef enum logic [2:0] {WAITING, RUNNING, PAUSED, CRASHED, RESTARTING} state_t;
   localparam int DEF_FPS         = 60;
   localparam int DEF_SPEED_W     = 15;
   localparam int DEF_START_SPEED = 6144;
   localparam int DEF_MAX_SPEED   = 13312;
   localparam int DEF_TIMER_W     = $clog2(DEF_FPS);
endpackage

// File: rtl/obstacle_pkg.sv
// obstacle_pkg: obstacle sprite constants.
package obstacle_pkg;
   localparam int COLLISION_BOX_COUNT = 2;
endpackage

// File: rtl/trex_pkg.sv
// trex_pkg: player sprite constants.
package trex_pkg;
   localparam int COLLISION_BOX_COUNT = 2;
endpackage

// File: rtl/game_loop_if.sv
// game_loop_if: game loop bus; master drives frame sync, keys and boxes, slave returns game status.
interface game_loop_if import game_loop_pkg::*, collision_pkg::*; #(
   parameter int TREX_BOXES = trex_pkg::COLLISION_BOX_COUNT,
   parameter int OBS_BOXES  = obstacle_pkg::COLLISION_BOX_COUNT,
   parameter int TIMER_W    = DEF_TIMER_W,
   parameter int SPEED_W    = DEF_SPEED_W
);
   logic                 painter_finished;
   logic                 jump;
   logic                 pause;
   collision_box_t       trex_box [TREX_BOXES];
   collision_box_t       obstacle_box [OBS_BOXES];
   state_t               state;
   logic                 update;
   logic                 step;
   logic [TIMER_W-1:0]   timer;
   logic [SPEED_W-1:0]   speed;
   logic                 start;
   logic                 restart;
   logic                 has_obstacles;
   logic [2:0]           lives;
   logic                 invincible;
   modport master (output painter_finished, jump, pause, trex_box, obstacle_box,
                   input state, update, step, timer, speed, start, restart, has_obstacles, lives, invincible);
   modport slave  (input painter_finished, jump, pause, trex_box, obstacle_box,
                   output state, update, step, timer, speed, start, restart, has_obstacles, lives, invincible);
endinterface

// File: rtl/collision_matrix.sv
// collision_matrix: registered OR of box_compare over every player/obstacle box pair.
//  clk, rst      clock, synchronous active-high reset
//  trex_box      player boxes
//  obstacle_box  obstacle boxes
//  hit_r         any pair overlapped on the previous cycle
module collision_matrix import collision_pkg::*; #(
   parameter int TREX_BOXES = trex_pkg::COLLISION_BOX_COUNT,
   parameter int OBS_BOXES  = obstacle_pkg::COLLISION_BOX_COUNT
) (
   input  logic           clk,
   input  logic           rst,
   input  collision_box_t trex_box [TREX_BOXES],
   input  collision_box_t obstacle_box [OBS_BOXES],
   output logic           hit_r
);
   logic hit_d, hit_q;
   always_comb begin
      hit_d = 1'b0;
      for (int i = 0; i < TREX_BOXES; i++)
         for (int j = 0; j < OBS_BOXES; j++)
            hit_d = hit_d | box_compare(trex_box[i], obstacle_box[j]);
   end
   always_ff @(posedge clk) hit_q <= rst ? 1'b0 : hit_d;
   assign hit_r = hit_q;
endmodule

// File: rtl/game_loop_ctrl.sv
// game_loop_ctrl: runner game loop with frame tick, speed ramp, obstacle gating, lives and pause.
//  clk, rst  clock, synchronous active-high reset
//  bus       game_loop_if slave: painter_finished/jump/pause/boxes in; state, update, step, timer,
//            speed, start, restart, has_obstacles, lives, invincible out
module game_loop_ctrl import game_loop_pkg::*; #(
   parameter int FPS           = DEF_FPS,
   parameter int SPEED_W       = DEF_SPEED_W,
   parameter int START_SPEED   = DEF_START_SPEED,
   parameter int MAX_SPEED     = DEF_MAX_SPEED,
   parameter int ACCEL         = 1,
   parameter int CLEAR_FRAMES  = 180,
   parameter int LIVES         = 3,
   parameter int INVULN_FRAMES = 90,
   parameter int TREX_BOXES    = trex_pkg::COLLISION_BOX_COUNT,
   parameter int OBS_BOXES     = obstacle_pkg::COLLISION_BOX_COUNT
) (
   input logic       clk,
   input logic       rst,
   game_loop_if.slave bus
);
   localparam int TIMER_W = $clog2(FPS);
   localparam int CLEAR_W = $clog2(CLEAR_FRAMES + 2);
   localparam int INV_W   = $clog2(INVULN_FRAMES + 1);
   localparam logic [SPEED_W:0] MAX_L = (SPEED_W+1)'(MAX_SPEED);
   state_t             state_q, state_d;
   logic               pf_q, jump_q, pause_q;
   logic               update_q, update_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic               start_q, start_d;
   logic [CLEAR_W-1:0] clear_q, clear_d;
   logic [INV_W-1:0]   inv_q, inv_d;
   logic [2:0]         lives_q, lives_d;
   logic               hit_r, step, pause_rise, jump_rise, hit_take;
   logic [SPEED_W:0]   speed_sum;
   collision_matrix #(.TREX_BOXES(TREX_BOXES), .OBS_BOXES(OBS_BOXES)) u_matrix (
      .clk(clk), .rst(rst), .trex_box(bus.trex_box), .obstacle_box(bus.obstacle_box), .hit_r(hit_r)
   );
   always_comb begin
      step       = update_q && state_q == RUNNING;
      pause_rise = bus.pause & ~pause_q;
      jump_rise  = bus.jump & ~jump_q;
      hit_take   = step && hit_r && inv_q == '0;
      speed_sum  = {1'b0, speed_q} + (SPEED_W+1)'(ACCEL);
      update_d   = bus.painter_finished & ~pf_q;
      timer_d    = update_q ? (timer_q == TIMER_W'(FPS - 1) ? '0 : timer_q + TIMER_W'(1)) : timer_q;
      state_d    = state_q;
      speed_d    = speed_q;
      start_d    = start_q;
      clear_d    = clear_q;
      inv_d      = inv_q;
      lives_d    = lives_q;
      if (state_q == WAITING && update_q && bus.jump) begin
         state_d = RUNNING;
         speed_d = SPEED_W'(START_SPEED);
         start_d = 1'b1;
      end
      if (step) begin
         speed_d = speed_sum <= MAX_L ? speed_sum[SPEED_W-1:0] : speed_q;
         clear_d = clear_q <= CLEAR_W'(CLEAR_FRAMES) ? clear_q + CLEAR_W'(1) : clear_q;
         inv_d   = inv_q != '0 ? inv_q - INV_W'(1) : inv_q;
      end
      // A hit is resolved before a simultaneous pause edge; a final-life hit swallows the pause.
      if (hit_take) begin
         lives_d = lives_q - 3'd1;
         if (lives_q == 3'd1) state_d = CRASHED;
         else inv_d = INV_W'(INVULN_FRAMES);
      end
      if (state_q == RUNNING && state_d == RUNNING && pause_rise) state_d = PAUSED;
      if (state_q == PAUSED && pause_rise) state_d = RUNNING;
      if (state_q == CRASHED && jump_rise) state_d = RESTARTING;
      if (state_q == RESTARTING && !bus.jump) state_d = WAITING;
      // Clearing on entry means lives/speed already show restart values in the first RESTARTING cycle.
      if (state_d == RESTARTING) begin
         speed_d = '0;
         start_d = 1'b0;
         clear_d = '0;
         inv_d   = '0;
         lives_d = 3'(LIVES);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= WAITING;
         pf_q     <= 1'b0;
         jump_q   <= 1'b0;
         pause_q  <= 1'b0;
         update_q <= 1'b0;
         timer_q  <= '0;
         speed_q  <= '0;
         start_q  <= 1'b0;
         clear_q  <= '0;
         inv_q    <= '0;
         lives_q  <= 3'(LIVES);
      end else begin
         state_q  <= state_d;
         pf_q     <= bus.painter_finished;
         jump_q   <= bus.jump;
         pause_q  <= bus.pause;
         update_q <= update_d;
         timer_q  <= timer_d;
         speed_q  <= speed_d;
         start_q  <= start_d;
         clear_q  <= clear_d;
         inv_q    <= inv_d;
         lives_q  <= lives_d;
      end
   end
   assign bus.state         = state_q;
   assign bus.update        = update_q;
   assign bus.step          = step;
   assign bus.timer         = timer_q;
   assign bus.speed         = speed_q;
   assign bus.start         = start_q;
   assign bus.restart       = state_d == RESTARTING;
   assign bus.has_obstacles = clear_q > CLEAR_W'(CLEAR_FRAMES);
   assign bus.lives         = lives_q;
   assign bus.invincible    = inv_q != '0;
endmodule
